lcd_ctrl_8bit: RTL



---
 rtl/lcd_pkg.sv | 49 ++++
 rtl/lcd_delay_counter.sv | 38 +++
 rtl/lcd_ctrl_8bit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 8-bit LCD controller.
//   - lcd_state_t : controller FSM states
//   - INIT_TABLE  : power-up command bytes, sent with RS=0, in index order
//   - CMD_CLEAR / CMD_HOME : the two commands that need the long execution wait
//   - TIMER_W     : width of the shared delay counter
package lcd_pkg;

  localparam int TIMER_W  = 20;
  localparam int INIT_LEN = 6;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Element [0] is sent first: function set x3, display on, clear, entry mode.
  localparam logic [INIT_LEN-1:0][7:0] INIT_TABLE = {
    8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38
  };

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_EN_HI    = 3'd3,
    ST_EXEC     = 3'd4,
    ST_IDLE     = 3'd5
  } lcd_state_t;

  // Index decode kept explicit so a 3-bit pointer never selects past the table.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = INIT_TABLE[0];
      3'd1:    b = INIT_TABLE[1];
      3'd2:    b = INIT_TABLE[2];
      3'd3:    b = INIT_TABLE[3];
      3'd4:    b = INIT_TABLE[4];
      3'd5:    b = INIT_TABLE[5];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Clear and home take ~2 ms on the panel; everything else ~50 us.
  function automatic logic needs_long_exec(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: up-counter used to time every controller state.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset (count -> 0)
//   clr   - synchronous clear, has priority over en
//   en    - count enable
//   load  - cycle count the current state must last (>= 1)
//   done  - high in the last cycle of a 'load'-cycle interval that began
//           with the counter at 0
module lcd_delay_counter
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] load,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Comparing against load-1 lets the owning state leave on exactly the
  // load-th edge after it was entered; the counter is cleared on that same
  // edge, so it never runs past load-1 and cannot wrap.
  assign done = (count == (load - 1'b1));

endmodule

// File: rtl/lcd_ctrl_8bit.sv
// lcd_ctrl_8bit: HD44780-compatible 8-bit character-LCD write controller.
// After reset it waits T_PWR cycles, sends the fixed init table, then raises
// oINIT_DONE/oREADY and accepts single-byte writes.
// Ports:
//   iCLK        - clock
//   iRST_n      - synchronous active-low reset
//   iREQ        - write request, taken on an edge where oREADY=1
//   iRS         - 0 = command, 1 = data
//   iDATA       - byte to write
//   oREADY      - controller can accept a request
//   oINIT_DONE  - init sequence finished (sticky until reset)
//   oLCD_DATA   - LCD DB7..DB0
//   oLCD_RS     - LCD RS
//   oLCD_RW     - LCD R/W, always 0 (write-only)
//   oLCD_EN     - LCD E, registered
module lcd_ctrl_8bit
  import lcd_pkg::*;
#(
  parameter int T_PWR   = 750000,
  parameter int T_SETUP = 5,
  parameter int T_EN    = 25,
  parameter int T_CMD   = 2500,
  parameter int T_CLR   = 100000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iREQ,
  input  logic       iRS,
  input  logic [7:0] iDATA,
  output logic       oREADY,
  output logic       oINIT_DONE,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oLCD_EN
);

  localparam logic [TIMER_W-1:0] T_PWR_V   = TIMER_W'(T_PWR);
  localparam logic [TIMER_W-1:0] T_SETUP_V = TIMER_W'(T_SETUP);
  localparam logic [TIMER_W-1:0] T_EN_V    = TIMER_W'(T_EN);
  localparam logic [TIMER_W-1:0] T_CMD_V   = TIMER_W'(T_CMD);
  localparam logic [TIMER_W-1:0] T_CLR_V   = TIMER_W'(T_CLR);
  localparam logic [2:0]         INIT_END  = 3'(INIT_LEN);

  lcd_state_t         state;
  lcd_state_t         state_next;
  logic [2:0]         init_ptr;
  logic [TIMER_W-1:0] load_val;
  logic               timer_done;
  logic               timer_en;
  logic               timer_clr;
  logic               accept;

  assign accept  = iREQ && oREADY;
  assign oLCD_RW = 1'b0;

  // Interval length for the current state. The EXEC wait is chosen from the
  // byte currently on the bus, which is the byte just strobed.
  always_comb begin
    load_val = 20'd1;
    case (state)
      ST_PWR_WAIT: load_val = T_PWR_V;
      ST_SETUP:    load_val = T_SETUP_V;
      ST_EN_HI:    load_val = T_EN_V;
      ST_EXEC:     load_val = needs_long_exec(oLCD_RS, oLCD_DATA) ? T_CLR_V : T_CMD_V;
      default:     load_val = 20'd1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_PWR_WAIT: if (timer_done) state_next = ST_LOAD;
      ST_LOAD:     state_next = ST_SETUP;
      ST_SETUP:    if (timer_done) state_next = ST_EN_HI;
      ST_EN_HI:    if (timer_done) state_next = ST_EXEC;
      ST_EXEC: begin
        // init_ptr parks at INIT_END once the table is exhausted, so user
        // writes always fall through to IDLE.
        if (timer_done) state_next = (init_ptr != INIT_END) ? ST_LOAD : ST_IDLE;
      end
      ST_IDLE:     if (accept) state_next = ST_SETUP;
      default:     state_next = ST_PWR_WAIT;
    endcase
  end

  // The timer only runs in the timed states and restarts on every transition.
  assign timer_en  = (state == ST_PWR_WAIT) || (state == ST_SETUP) ||
                     (state == ST_EN_HI)    || (state == ST_EXEC);
  assign timer_clr = (state_next != state);

  lcd_delay_counter u_delay (
    .clk   (iCLK),
    .rst_n (iRST_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .load  (load_val),
    .done  (timer_done)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state      <= ST_PWR_WAIT;
      init_ptr   <= 3'd0;
      oREADY     <= 1'b0;
      oINIT_DONE <= 1'b0;
      oLCD_DATA  <= 8'h00;
      oLCD_RS    <= 1'b0;
      oLCD_EN    <= 1'b0;
    end else begin
      state <= state_next;

      if (state == ST_LOAD) begin
        oLCD_DATA <= init_byte(init_ptr);
        oLCD_RS   <= 1'b0;
        init_ptr  <= init_ptr + 3'd1;
      end

      if (accept) begin
        oLCD_DATA <= iDATA;
        oLCD_RS   <= iRS;
        oREADY    <= 1'b0;
      end

      if ((state == ST_EXEC) && (state_next == ST_IDLE)) begin
        oREADY     <= 1'b1;
        oINIT_DONE <= 1'b1;
      end

      // Registered from the next state so E is high for exactly the cycles
      // spent in EN_HI and never glitches.
      oLCD_EN <= (state_next == ST_EN_HI);
    end
  end

endmodule
